// File: rtl/scie_fir_multichannel_if.sv
// ============================================================================
// Module      : scie_fir_multichannel_if
// Description : SCIE custom-instruction port bundle for the multi-channel FIR.
//               The core side (master) issues instructions and operands; the
//               FIR unit (slave) returns one registered result per accepted op.
// Signals     : io_valid    - instruction issue strobe
//               io_insn     - 32-bit instruction word
//               io_rs1      - operand: coefficient or signed sample
//               io_rs2      - operand: tap index or channel index
//               io_rd       - result
//               io_rd_valid - result strobe
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scie_fir_multichannel_if #(
  parameter int XLEN = 32
);
  logic            io_valid;
  logic [31:0]     io_insn;
  logic [XLEN-1:0] io_rs1;
  logic [XLEN-1:0] io_rs2;
  logic [XLEN-1:0] io_rd;
  logic            io_rd_valid;

  modport master (
    output io_valid, io_insn, io_rs1, io_rs2,
    input  io_rd, io_rd_valid
  );

  modport slave (
    input  io_valid, io_insn, io_rs1, io_rs2,
    output io_rd, io_rd_valid
  );
endinterface

`default_nettype wire

// File: rtl/scie_fir_multichannel.sv
// ============================================================================
// Module      : scie_fir_multichannel
// Description : Pipelined multi-channel FIR on the SCIE custom-instruction
//               port. Per-channel sample history, shared coefficient table,
//               every accepted op returns exactly one response two cycles
//               after issue. Opcode 7'h0B, funct3 selects LDCOEF / PUSH /
//               READ / CLEAR / PUSHRD (5-7 are accepted NOPs).
// Ports       : clock - rising-edge clock
//               reset - synchronous, active-low
//               bus   - scie_fir_multichannel_if.slave (io_valid, io_insn,
//                       io_rs1, io_rs2 in; io_rd, io_rd_valid out)
// Config      : `define SCIE_FIR_SAT_EN to saturate the shifted accumulator
//               to signed XLEN range; otherwise the low XLEN bits are kept.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scie_fir_multichannel #(
  parameter int XLEN     = 32,
  parameter int TAPS     = 4,
  parameter int CHANNELS = 2,
  parameter int COEF_W   = 16,
  parameter int SHIFT    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  scie_fir_multichannel_if.slave bus
);

  localparam int PROD_W = XLEN + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TAP_W  = $clog2(TAPS);

  localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
  localparam logic [2:0] F3_LDCOEF   = 3'd0;
  localparam logic [2:0] F3_PUSH     = 3'd1;
  localparam logic [2:0] F3_READ     = 3'd2;
  localparam logic [2:0] F3_CLEAR    = 3'd3;
  localparam logic [2:0] F3_PUSHRD   = 3'd4;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'({1'b0, {(XLEN-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  // --------------------------------------------------------------------------
  // S0: decode
  // --------------------------------------------------------------------------
  logic             w_accept;
  logic [2:0]       w_f3;
  logic             w_ch_ok;
  logic             w_tap_ok;
  logic [CH_W-1:0]  w_ch;
  logic [TAP_W-1:0] w_tap;
  logic             w_do_push;
  logic             w_do_ld;
  logic             w_do_clr;
  logic             w_do_read;
  logic             w_ret_y;

  assign w_accept  = bus.io_valid && (bus.io_insn[6:0] == OPC_CUSTOM0);
  assign w_f3      = bus.io_insn[14:12];
  // Full-width compares so large rs2 values never alias into a valid index.
  assign w_ch_ok   = bus.io_rs2 < XLEN'(CHANNELS);
  assign w_tap_ok  = bus.io_rs2 < XLEN'(TAPS);
  assign w_ch      = bus.io_rs2[CH_W-1:0];
  assign w_tap     = bus.io_rs2[TAP_W-1:0];

  assign w_do_push = w_accept && w_ch_ok && ((w_f3 == F3_PUSH) || (w_f3 == F3_PUSHRD));
  assign w_do_ld   = w_accept && w_tap_ok && (w_f3 == F3_LDCOEF);
  assign w_do_clr  = w_accept && w_ch_ok && (w_f3 == F3_CLEAR);
  assign w_do_read = w_accept && w_ch_ok && (w_f3 == F3_READ);
  assign w_ret_y   = w_accept && w_ch_ok && (w_f3 == F3_PUSHRD);

  // --------------------------------------------------------------------------
  // S0: coefficient table and per-channel history (TAPS-1 past samples)
  // --------------------------------------------------------------------------
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [XLEN-1:0]   hist_q [CHANNELS][TAPS-1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) coef_q[k] <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS - 1; k++) hist_q[c][k] <= '0;
    end else begin
      if (w_do_ld) coef_q[w_tap] <= bus.io_rs1[COEF_W-1:0];
      if (w_do_push) begin
        hist_q[w_ch][0] <= bus.io_rs1;
        for (int k = 1; k < TAPS - 1; k++) hist_q[w_ch][k] <= hist_q[w_ch][k-1];
      end else if (w_do_clr) begin
        for (int k = 0; k < TAPS - 1; k++) hist_q[w_ch][k] <= '0;
      end
    end
  end

  // Sample window x[n-k]: the incoming operand plus the stored history.
  logic signed [XLEN-1:0] w_win [TAPS];
  always_comb begin
    w_win[0] = bus.io_rs1;
    for (int k = 1; k < TAPS; k++) w_win[k] = hist_q[w_ch][k-1];
  end

  logic signed [PROD_W-1:0] w_prod [TAPS];
  for (genvar k = 0; k < TAPS; k++) begin : g_prod
    assign w_prod[k] = PROD_W'(w_win[k]) * PROD_W'(coef_q[k]);
  end

  // --------------------------------------------------------------------------
  // S1: product register
  // --------------------------------------------------------------------------
  logic                     v1_q;
  logic                     wr1_q;
  logic                     ret1_q;
  logic                     rdop1_q;
  logic                     clr1_q;
  logic [CH_W-1:0]          ch1_q;
  logic signed [PROD_W-1:0] prod1_q [TAPS];

  always_ff @(posedge clock) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      wr1_q   <= 1'b0;
      ret1_q  <= 1'b0;
      rdop1_q <= 1'b0;
      clr1_q  <= 1'b0;
      ch1_q   <= '0;
      for (int k = 0; k < TAPS; k++) prod1_q[k] <= '0;
    end else begin
      v1_q    <= w_accept;
      wr1_q   <= w_do_push;
      ret1_q  <= w_ret_y;
      rdop1_q <= w_do_read;
      clr1_q  <= w_do_clr;
      ch1_q   <= w_ch;
      for (int k = 0; k < TAPS; k++) prod1_q[k] <= w_prod[k];
    end
  end

  // --------------------------------------------------------------------------
  // S2: adder tree. The sum is registered before the shift/narrow/output
  // step so the carry chain and the saturation compare sit in different
  // cycles; the response still lands two edges after issue.
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] w_sum;
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++)
      w_sum = w_sum + {{(ACC_W-PROD_W){prod1_q[k][PROD_W-1]}}, prod1_q[k]};
  end

  logic                    v2_q;
  logic                    wr2_q;
  logic                    ret2_q;
  logic                    rdop2_q;
  logic                    clr2_q;
  logic [CH_W-1:0]         ch2_q;
  logic signed [ACC_W-1:0] acc2_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      v2_q    <= 1'b0;
      wr2_q   <= 1'b0;
      ret2_q  <= 1'b0;
      rdop2_q <= 1'b0;
      clr2_q  <= 1'b0;
      ch2_q   <= '0;
      acc2_q  <= '0;
    end else begin
      v2_q    <= v1_q;
      wr2_q   <= wr1_q;
      ret2_q  <= ret1_q;
      rdop2_q <= rdop1_q;
      clr2_q  <= clr1_q;
      ch2_q   <= ch1_q;
      acc2_q  <= w_sum;
    end
  end

  logic signed [ACC_W-1:0] w_shifted;
  logic [XLEN-1:0]         y_d;
  logic                    w_unused;

  assign w_shifted = acc2_q >>> SHIFT;

`ifdef SCIE_FIR_SAT_EN
  always_comb begin
    y_d = w_shifted[XLEN-1:0];
    if (w_shifted > Y_MAX)      y_d = Y_MAX[XLEN-1:0];
    else if (w_shifted < Y_MIN) y_d = Y_MIN[XLEN-1:0];
  end
  assign w_unused = ^{bus.io_insn[31:15], bus.io_insn[11:7]};
`else
  assign y_d      = w_shifted[XLEN-1:0];
  assign w_unused = ^{bus.io_insn[31:15], bus.io_insn[11:7], w_shifted[ACC_W-1:XLEN],
                      Y_MIN[0]};
`endif

  // --------------------------------------------------------------------------
  // Output and result registers. Res updates and the READ lookup share this
  // edge, so a READ one cycle behind a PUSH sees the PUSH's result, and a
  // CLEAR zeroes res after any earlier in-flight PUSH has written it.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] res_q [CHANNELS];
  logic [XLEN-1:0] rd_q;
  logic [XLEN-1:0] rd_d;
  logic            rd_valid_q;

  always_comb begin
    rd_d = '0;
    if (rdop2_q)     rd_d = res_q[ch2_q];
    else if (ret2_q) rd_d = y_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) res_q[c] <= '0;
    end else begin
      rd_valid_q <= v2_q;
      if (v2_q) rd_q <= rd_d;
      if (wr2_q)       res_q[ch2_q] <= y_d;
      else if (clr2_q) res_q[ch2_q] <= '0;
    end
  end

  assign bus.io_rd       = rd_q;
  assign bus.io_rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_scie_fir_multichannel.sv
// ============================================================================
// Module      : tb_scie_fir_multichannel
// Description : Self-checking bench for scie_fir_multichannel (default
//               parameters). An in-order instruction-level model produces the
//               expected response of every accepted op; a compare process
//               checks io_rd_valid / io_rd on every cycle against it, and
//               directed ops carry hand-computed literal results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scie_fir_multichannel;

  localparam int XLEN  = 32;
  localparam int SHIFT = 0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  scie_fir_multichannel_if #(.XLEN(XLEN)) bus ();

  scie_fir_multichannel #(
    .XLEN(XLEN), .TAPS(4), .CHANNELS(2), .COEF_W(16), .SHIFT(SHIFT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] rd;
    bit          has_lit;
    logic [31:0] lit;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc     = 0;
  int          checks  = 0;
  int          errors  = 0;
  bit          run_chk = 1'b0;
  logic [31:0] last_rd = '0;

  longint      m_coef [4];
  longint      m_hist [2][4];
  logic [31:0] m_res  [2];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] narrow(input longint acc);
    longint s;
    s = acc >>> SHIFT;
`ifdef SCIE_FIR_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) m_coef[k] = 0;
    for (int c = 0; c < 2; c++) begin
      m_res[c] = '0;
      for (int k = 0; k < 4; k++) m_hist[c][k] = 0;
    end
  endtask

  // Drive one instruction for one cycle, then apply it to the model.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [31:0] rs2, input bit lit_en, input logic [31:0] lit);
    logic [31:0] r;
    longint      a;
    logic [31:0] y;
    int          ch;
    exp_t        e;
    bus.io_valid = 1'b1;
    bus.io_insn  = {17'd0, f3, 5'd0, opc};
    bus.io_rs1   = rs1;
    bus.io_rs2   = rs2;
    @(posedge clock);
    #1;
    if (opc == 7'h0B) begin
      r  = '0;
      ch = int'(rs2[0]);
      case (f3)
        3'd0: if (rs2 < 4) m_coef[rs2[1:0]] = longint'($signed(rs1[15:0]));
        3'd1, 3'd4: if (rs2 < 2) begin
          for (int k = 3; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
          m_hist[ch][0] = longint'($signed(rs1));
          a = 0;
          for (int k = 0; k < 4; k++) a += m_coef[k] * m_hist[ch][k];
          y = narrow(a);
          m_res[ch] = y;
          if (f3 == 3'd4) r = y;
        end
        3'd2: if (rs2 < 2) r = m_res[ch];
        3'd3: if (rs2 < 2) begin
          m_res[ch] = '0;
          for (int k = 0; k < 4; k++) m_hist[ch][k] = 0;
        end
        default: ;
      endcase
      e.due = cyc + 2; e.rd = r; e.has_lit = lit_en; e.lit = lit;
      exp_q.push_back(e);
    end
  endtask

  task automatic op(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                    input bit lit_en, input logic [31:0] lit);
    issue(7'h0B, f3, rs1, rs2, lit_en, lit);
  endtask

  task automatic idle(input int n);
    bus.io_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.io_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    model_clear();
    exp_q.delete();
    last_rd = '0;
    reset = 1'b1;
  endtask

  task automatic load_1234();
    op(3'd0, 32'd1, 32'd0, 1'b1, 32'd0);
    op(3'd0, 32'd2, 32'd1, 1'b1, 32'd0);
    op(3'd0, 32'd3, 32'd2, 1'b1, 32'd0);
    op(3'd0, 32'd4, 32'd3, 1'b1, 32'd0);
  endtask

  always @(negedge clock) begin
    if (run_chk) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("rd_valid", {31'd0, bus.io_rd_valid}, 32'd1);
        chk("rd_model", bus.io_rd, exp_q[0].rd);
        if (exp_q[0].has_lit) chk("rd_literal", bus.io_rd, exp_q[0].lit);
        last_rd = exp_q[0].rd;
        void'(exp_q.pop_front());
      end else begin
        chk("rd_valid_idle", {31'd0, bus.io_rd_valid}, 32'd0);
        chk("rd_hold", bus.io_rd, last_rd);
      end
    end
  end

  initial begin
    bus.io_valid = 1'b0;
    bus.io_insn  = '0;
    bus.io_rs1   = '0;
    bus.io_rs2   = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b1;
    run_chk = 1'b1;
    chk("reset_rd", bus.io_rd, 32'd0);
    chk("reset_rd_valid", {31'd0, bus.io_rd_valid}, 32'd0);

    // Basic filter and channel isolation
    load_1234();
    op(3'd4, 32'd10, 32'd0, 1'b1, 32'd10);
    op(3'd4, 32'd20, 32'd0, 1'b1, 32'd40);
    op(3'd4, 32'd30, 32'd0, 1'b1, 32'd100);
    op(3'd4, 32'd5,  32'd1, 1'b1, 32'd5);
    op(3'd2, 32'd0,  32'd0, 1'b1, 32'd100);
    idle(4);

    // Back-to-back PUSH then READ of the same channel
    do_reset();
    load_1234();
    op(3'd1, 32'd7, 32'd0, 1'b1, 32'd0);
    op(3'd2, 32'd0, 32'd0, 1'b1, 32'd7);
    idle(4);

    // Saturation / wrap
    do_reset();
    op(3'd0, 32'd32767, 32'd0, 1'b1, 32'd0);
`ifdef SCIE_FIR_SAT_EN
    op(3'd4, 32'h7FFFFFFF, 32'd0, 1'b1, 32'h7FFFFFFF);
`else
    op(3'd4, 32'h7FFFFFFF, 32'd0, 1'b1, 32'h7FFF8001);
`endif
    idle(1);

    // Illegal opcode, out-of-range indices, channel state preserved
    issue(7'h2B, 3'd4, 32'd55, 32'd0, 1'b0, 32'd0);
    idle(3);
    op(3'd4, 32'd123, 32'd2, 1'b1, 32'd0);
`ifdef SCIE_FIR_SAT_EN
    op(3'd2, 32'd0, 32'd0, 1'b1, 32'h7FFFFFFF);
`else
    op(3'd2, 32'd0, 32'd0, 1'b1, 32'h7FFF8001);
`endif
    op(3'd2, 32'd0, 32'd1, 1'b1, 32'd0);
    op(3'd0, 32'd99, 32'd4, 1'b1, 32'd0);
    op(3'd4, 32'd1, 32'd1, 1'b1, 32'd32767);
    op(3'd2, 32'd0, 32'd9, 1'b1, 32'd0);
    idle(4);

    // Negative values, CLEAR, NOP
    do_reset();
    op(3'd0, 32'hFFFFFFFD, 32'd0, 1'b1, 32'd0);
    op(3'd0, 32'd5, 32'd1, 1'b1, 32'd0);
    op(3'd4, 32'hFFFFFFFC, 32'd1, 1'b1, 32'd12);
    op(3'd4, 32'd6, 32'd1, 1'b1, 32'hFFFFFFDA);
    op(3'd3, 32'd0, 32'd1, 1'b1, 32'd0);
    op(3'd4, 32'd2, 32'd1, 1'b1, 32'hFFFFFFFA);
    op(3'd2, 32'd0, 32'd1, 1'b1, 32'hFFFFFFFA);
    op(3'd6, 32'd77, 32'd0, 1'b1, 32'd0);
    idle(4);

    // Reset while a PUSHRD sits in S1
    do_reset();
    op(3'd0, 32'd1, 32'd0, 1'b1, 32'd0);
    idle(3);
    op(3'd4, 32'd9, 32'd0, 1'b0, 32'd0);
    do_reset();
    op(3'd2, 32'd0, 32'd0, 1'b1, 32'd0);
    op(3'd4, 32'd9, 32'd0, 1'b1, 32'd0);
    idle(6);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
